// File: rtl/lane_op_pkg.sv
// Shared types for the lane operation sequencer.
// State encoding, lane/flag widths and the captured result word.
package lane_op_pkg;

  localparam int LANES  = 4;
  localparam int FLAG_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [LANES-1:0]  sum;
    logic [FLAG_W-1:0] flag;
  } res_t;

endpackage

// File: rtl/lane_op_sequencer_rsp_fifo2.sv
// rsp_fifo2: 2-entry in-order response FIFO, push+pop legal at full.
// Ports: i_push/i_data write, i_ready consumes head, o_valid/o_data head
// (zero when empty), o_count occupancy, o_pop = head consumed this cycle.
module rsp_fifo2 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count,
  output logic         o_pop
);

  logic [W-1:0] r_mem [2];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_cnt;
  logic         w_push;

  assign o_pop   = (r_cnt != 2'd0) & i_ready;
  assign w_push  = i_push & ((r_cnt != 2'd2) | o_pop);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (o_pop)
        r_rd <= ~r_rd;
      r_cnt <= r_cnt + 2'(w_push) - 2'(o_pop);
    end
  end

endmodule

// File: rtl/lane_op_sequencer.sv
// lane_op_sequencer: drives registered operands to a combinational lane
// unit, waits SETTLE_CYC cycles, captures result/flags and returns them
// tagged through a 2-entry response buffer.
// Ports: cmd_* valid/ready command in, op_* registered unit pins,
// res_* unit results in, rsp_* valid/ready tagged response out, busy.
module lane_op_sequencer
  import lane_op_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [3:0]       cmd_sel,
  input  logic             cmd_cin,
  input  logic             cmd_en,
  output logic [3:0]       op_a,
  output logic [3:0]       op_b,
  output logic [3:0]       op_sel,
  output logic             op_cin,
  output logic             op_en,
  input  logic [3:0]       res_sum,
  input  logic [3:0]       res_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_sum,
  output logic [3:0]       rsp_flag,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int DW = LANES + FLAG_W + TAG_W;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [TAG_W-1:0] r_tag;
  logic [3:0]       r_op_a;
  logic [3:0]       r_op_b;
  logic [3:0]       r_op_sel;
  logic             r_op_cin;
  logic             r_op_en;
  logic             r_pend;
  logic             r_live;
  logic [DW-1:0]    r_stage;

  logic [1:0]       w_fcnt;
  logic             w_pop;
  logic             w_can;
  logic             w_cap;
  logic             w_push;
  logic             w_accept;
  logic [DW-1:0]    w_pdata;
  logic [DW-1:0]    w_head;
  res_t             w_res;
  res_t             w_rsp;

  assign w_res    = '{sum: res_sum, flag: res_flag};
  // A slot is free now, or the head leaves in this same cycle.
  assign w_can    = (w_fcnt != 2'd2) | w_pop;
  assign w_cap    = (r_state == S_SETTLE) && (r_cnt == 4'd0);
  assign w_push   = w_can & (w_cap | r_pend);
  assign w_pdata  = r_pend ? r_stage : {w_res, r_tag};
  // r_live keeps cmd_ready low while rst is held.
  assign cmd_ready = r_live & (r_state == S_IDLE) & (w_fcnt != 2'd2);
  assign w_accept = cmd_valid & cmd_ready;

  rsp_fifo2 #(.W(DW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_pdata),
    .i_ready (rsp_ready),
    .o_valid (rsp_valid),
    .o_data  (w_head),
    .o_count (w_fcnt),
    .o_pop   (w_pop)
  );

  assign w_rsp    = res_t'(w_head[DW-1:TAG_W]);
  assign rsp_sum  = w_rsp.sum;
  assign rsp_flag = w_rsp.flag;
  assign rsp_tag  = w_head[TAG_W-1:0];

  assign op_a   = r_op_a;
  assign op_b   = r_op_b;
  assign op_sel = r_op_sel;
  assign op_cin = r_op_cin;
  assign op_en  = r_op_en;
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_tag    <= '0;
      r_op_a   <= 4'd0;
      r_op_b   <= 4'd0;
      r_op_sel <= 4'd0;
      r_op_cin <= 1'b0;
      r_op_en  <= 1'b0;
      r_pend   <= 1'b0;
      r_live   <= 1'b0;
      r_stage  <= '0;
    end else begin
      r_live <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a   <= cmd_a;
            r_op_b   <= cmd_b;
            r_op_sel <= cmd_sel;
            r_op_cin <= cmd_cin;
            r_op_en  <= cmd_en;
            r_state  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_cnt   <= 4'(SETTLE_CYC - 1);
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) begin
            // Sample results now; stage them if the buffer is full.
            r_tag   <= r_tag + 1'b1;
            r_state <= S_CAPTURE;
            if (!w_can) begin
              r_pend  <= 1'b1;
              r_stage <= {w_res, r_tag};
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CAPTURE: begin
          if (r_pend && !w_can)
            r_state <= S_HOLD;
          else begin
            r_pend  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (w_can) begin
            r_pend  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_op_sequencer.sv
// Randomized bench for lane_op_sequencer with a transaction-level
// scoreboard and a lane unit model that only settles after S cycles.
module tb_lane_op_sequencer;

  localparam int S = 2;

  logic       clk = 0;
  logic       rst = 1;
  logic       cmd_valid = 0;
  logic       cmd_ready;
  logic [3:0] cmd_a = 0, cmd_b = 0, cmd_sel = 0;
  logic       cmd_cin = 0, cmd_en = 0;
  logic [3:0] op_a, op_b, op_sel;
  logic       op_cin, op_en;
  logic [3:0] res_sum, res_flag;
  logic       rsp_valid;
  logic       rsp_ready = 0;
  logic [3:0] rsp_sum, rsp_flag, rsp_tag;
  logic       busy;

  always #5 clk = ~clk;

  lane_op_sequencer #(.SETTLE_CYC(S), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .cmd_cin(cmd_cin), .cmd_en(cmd_en),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .op_cin(op_cin), .op_en(op_en),
    .res_sum(res_sum), .res_flag(res_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_flag(rsp_flag), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane unit: 4-bit add with carry-in, flags mix sel/carry/en.
  function automatic logic [7:0] unit_f(input logic [13:0] c);
    logic [4:0] s;
    s = {1'b0, c[13:10]} + {1'b0, c[9:6]} + {4'b0, c[1]};
    return {s[3:0], c[5:2] ^ {s[4], c[0], 2'b00}};
  endfunction

  // Outputs are garbage until operands have been stable S cycles.
  int         age = 255;
  logic [7:0] u_out;
  always_comb begin
    u_out = unit_f({op_a, op_b, op_sel, op_cin, op_en});
    if (age < S) u_out = ~u_out;
  end
  assign res_sum  = u_out[7:4];
  assign res_flag = u_out[3:0];

  logic [11:0] q[$];
  logic [3:0]  m_tag = 0;
  logic [13:0] m_op = 0;
  logic [3:0]  last_tag = 0;
  int          n_rsp = 0;
  bit          armed = 0;
  logic [7:0]  u;

  always @(posedge clk) begin
    if (armed) begin
      check("op_hold", {op_a, op_b, op_sel, op_cin, op_en}, m_op);
      if (rsp_valid) begin
        if (q.size() == 0) check("rsp_unexp", 1, 0);
        else check("rsp_head", {rsp_sum, rsp_flag, rsp_tag}, q[0]);
      end else begin
        check("rsp_zero", {rsp_sum, rsp_flag, rsp_tag}, 0);
      end
    end
    if (rst) begin
      q.delete();
      m_tag = 0;
      m_op  = 0;
      age  <= 255;
      armed = 1;
    end else begin
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        last_tag = rsp_tag;
        void'(q.pop_front());
        n_rsp++;
      end
      if (cmd_valid && cmd_ready) begin
        m_op = {cmd_a, cmd_b, cmd_sel, cmd_cin, cmd_en};
        u = unit_f(m_op);
        q.push_back({u, m_tag});
        m_tag = m_tag + 4'd1;
        age <= 0;
      end else if (age < 255) begin
        age <= age + 1;
      end
    end
  end

  // 0: hold low, 1: hold high, 2: random each cycle
  int rdy_mode = 1;
  always @(posedge clk) begin
    #2;
    rsp_ready = (rdy_mode == 2) ? 1'($urandom) : rdy_mode[0];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) @(posedge clk);
    #1;
    check("rst_out", {cmd_ready, op_a, op_b, op_sel, op_cin, op_en,
                      rsp_valid, rsp_sum, rsp_flag, rsp_tag, busy}, 0);
    rst = 0;
  endtask

  task automatic send(input logic [13:0] c);
    int b = 0;
    {cmd_a, cmd_b, cmd_sel, cmd_cin, cmd_en} = c;
    cmd_valid = 1;
    while (!cmd_ready && b < 200) begin
      step();
      b++;
    end
    if (!cmd_ready) check("send_timeout", 0, 1);
    else step();
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic drain();
    int b = 0;
    while (q.size() != 0 && b < 300) begin
      step();
      b++;
    end
    check("drain", q.size(), 0);
  endtask

  int          lat;
  int          n0;
  logic [13:0] c3;

  initial begin
    rdy_mode = 1;
    do_reset(3);
    step();
    check("rdy_after_rst", cmd_ready, 1);

    send({4'hA, 4'hB, 4'h3, 1'b0, 1'b0});
    check("op_a_t1", op_a, 4'hA);
    check("busy_drive", busy, 1);
    wait_rsp(lat);
    check("latency", lat, S + 2);
    check("single_sum", rsp_sum, 4'h5);
    check("single_tag", rsp_tag, 0);
    drain();

    rdy_mode = 0;
    do_reset(2);
    n0 = n_rsp;
    send(14'($urandom));
    send(14'($urandom));
    c3 = 14'($urandom);
    {cmd_a, cmd_b, cmd_sel, cmd_cin, cmd_en} = c3;
    cmd_valid = 1;
    repeat (S + 6) step();
    check("bp_rdy_low", cmd_ready, 0);
    check("bp_head_tag", rsp_tag, 0);
    check("bp_valid", rsp_valid, 1);
    rdy_mode = 1;
    step();
    rdy_mode = 0;
    check("bp_one_pop", n_rsp - n0, 1);
    send(c3);
    rdy_mode = 1;
    drain();
    check("bp_count", n_rsp - n0, 3);
    check("bp_last_tag", last_tag, 2);

    do_reset(2);
    rdy_mode = 2;
    n0 = n_rsp;
    repeat (17) send(14'($urandom));
    rdy_mode = 1;
    drain();
    check("wrap_count", n_rsp - n0, 17);
    check("wrap_last_tag", last_tag, 0);

    do_reset(2);
    rdy_mode = 0;
    send(14'($urandom));
    wait_rsp(lat);
    check("mid_buffered", rsp_valid, 1);
    send(14'($urandom));
    step();
    rst = 1;
    step();
    check("mid_rst", {rsp_valid, busy, op_a, op_b, op_sel, op_cin, op_en},
          0);
    rst = 0;
    rdy_mode = 1;
    send(14'($urandom));
    wait_rsp(lat);
    check("mid_tag0", {rsp_valid, rsp_tag}, {1'b1, 4'h0});
    drain();

    rdy_mode = 2;
    n0 = n_rsp;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) step();
      send(14'($urandom));
    end
    rdy_mode = 1;
    drain();
    check("rand_count", n_rsp - n0, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
